// File: rtl/intt_result_collector.sv
// intt_result_collector: reassembles INTT 128-bit write beats into three
// 4096-bit polynomial slots and serves whole polynomials on a 1-cycle read port.
module intt_result_collector #(
    parameter  int unsigned KYBER_N      = 256,
    parameter  int unsigned COEFFS_WIDTH = 16,
    parameter  int unsigned BEAT_WIDTH   = 128,
    localparam int unsigned POLY_SIZE    = COEFFS_WIDTH * KYBER_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mux_enc_dec,
    input  logic                  wr_valid,
    input  logic [6:0]            wr_addr,
    input  logic [BEAT_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [1:0]            rd_slot,
    output logic                  rd_valid,
    output logic [POLY_SIZE-1:0]  rd_poly,
    output logic [2:0]            slot_valid,
    output logic                  all_done,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned BEATS_PER_POLY = POLY_SIZE / BEAT_WIDTH;
    localparam int unsigned NUM_SLOTS      = 3;
    localparam int unsigned NUM_WORDS      = NUM_SLOTS * BEATS_PER_POLY;
    localparam int unsigned CNT_W          = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [BEAT_WIDTH-1:0] mem [NUM_WORDS];
    logic [CNT_W-1:0]      cnt_q [NUM_SLOTS];
    logic                  mode_q;

    logic [1:0]           wr_slot_c;
    logic [1:0]           wr_slot_idx_c;
    logic [CNT_W-1:0]     wr_word_c;
    logic                 wr_addr_ok_c;
    logic [2:0]           req_mask_c;
    logic                 accept_c;
    logic                 wr_err_c;
    logic [2:0]           slot_set_c;
    logic [2:0]           slot_valid_nxt_c;
    logic                 mask_done_c;
    logic [1:0]           rd_slot_idx_c;
    logic                 rd_ok_c;
    logic                 rd_err_c;
    logic [POLY_SIZE-1:0] rd_poly_c;

    // Write-beat decode and acceptance; slot 3 is clamped for safe indexing
    always_comb begin
        wr_slot_c     = wr_addr[6:5];
        wr_word_c     = wr_addr[4:0];
        wr_addr_ok_c  = (wr_slot_c != 2'd3);
        wr_slot_idx_c = wr_addr_ok_c ? wr_slot_c : 2'd0;
        req_mask_c    = mode_q ? 3'b001 : 3'b111;
        accept_c      = wr_valid && !start && (state == COLLECT) && wr_addr_ok_c
                        && !slot_valid[wr_slot_idx_c] && req_mask_c[wr_slot_idx_c]
                        && (wr_word_c == cnt_q[wr_slot_idx_c]);
        wr_err_c      = wr_valid && !start && (state != IDLE) && !accept_c;
        slot_set_c    = 3'b000;
        if (accept_c && (wr_word_c == CNT_W'(BEATS_PER_POLY - 1))) begin
            slot_set_c[wr_slot_idx_c] = 1'b1;
        end
        slot_valid_nxt_c = slot_valid | slot_set_c;
        mask_done_c      = ((slot_valid_nxt_c & req_mask_c) == req_mask_c);
    end

    // Read decode against pre-write slot state, plus polynomial gather
    always_comb begin
        rd_slot_idx_c = (rd_slot == 2'd3) ? 2'd0 : rd_slot;
        rd_ok_c       = rd_req && !start && (state != IDLE) && (rd_slot != 2'd3)
                        && slot_valid[rd_slot_idx_c];
        rd_err_c      = rd_req && !start && !rd_ok_c;
        rd_poly_c     = '0;
        for (int k = 0; k < BEATS_PER_POLY; k++) begin
            rd_poly_c[k*BEAT_WIDTH +: BEAT_WIDTH] = mem[{rd_slot_idx_c, CNT_W'(k)}];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start re-enters COLLECT from any state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (start)            state_nxt = COLLECT;
                else if (mask_done_c) state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat storage; contents need no reset
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Control, status and read-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_poly    <= '0;
            slot_valid <= 3'b000;
            all_done   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            mode_q     <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) cnt_q[s] <= '0;
        end else begin
            rd_valid <= rd_ok_c;
            if (rd_ok_c) rd_poly <= rd_poly_c;
            busy     <= (state_nxt == COLLECT);
            all_done <= (state_nxt == DONE);
            if (start) begin
                slot_valid <= 3'b000;
                err        <= 1'b0;
                mode_q     <= mux_enc_dec;
                for (int s = 0; s < NUM_SLOTS; s++) cnt_q[s] <= '0;
            end else begin
                slot_valid <= slot_valid_nxt_c;
                err        <= err | wr_err_c | rd_err_c;
                if (accept_c) begin
                    cnt_q[wr_slot_idx_c] <= cnt_q[wr_slot_idx_c] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_intt_result_collector.sv
// Directed bench for intt_result_collector with a read-data scoreboard.
module tb_intt_result_collector;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mux_enc_dec = 1'b0;
    logic          wr_valid = 1'b0;
    logic [6:0]    wr_addr = '0;
    logic [127:0]  wr_data = '0;
    logic          rd_req = 1'b0;
    logic [1:0]    rd_slot = '0;
    logic          rd_valid;
    logic [4095:0] rd_poly;
    logic [2:0]    slot_valid;
    logic          all_done;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;
    logic [4095:0] exp_q [$];

    intt_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .mux_enc_dec(mux_enc_dec),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_poly(rd_poly),
        .slot_valid(slot_valid), .all_done(all_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat(int a);
        logic [7:0] b;
        b = 8'(a);
        return {16{b}};
    endfunction

    function automatic logic [4095:0] exp_poly(int s);
        logic [4095:0] p;
        for (int k = 0; k < 32; k++) p[k*128 +: 128] = pat(32*s + k);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic beat(int a);
        wr_valid = 1'b1;
        wr_addr  = 7'(a);
        wr_data  = pat(a);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic beats(int lo, int hi);
        for (int a = lo; a <= hi; a++) beat(a);
    endtask

    task automatic do_start(logic m);
        start = 1'b1;
        mux_enc_dec = m;
        tick();
        start = 1'b0;
    endtask

    task automatic do_read(int s, logic ok);
        rd_req  = 1'b1;
        rd_slot = 2'(s);
        if (ok) exp_q.push_back(exp_poly(s));
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected polynomial
    always @(negedge clk) begin
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid=1 with no read expected");
            end else begin
                logic [4095:0] e;
                e = exp_q.pop_front();
                if (rd_poly !== e) begin
                    errors++;
                    for (int k = 0; k < 32; k++) begin
                        if (rd_poly[k*128 +: 128] !== e[k*128 +: 128]) begin
                            $display("FAIL rd_poly word %0d: got %h expected %h",
                                     k, rd_poly[k*128 +: 128], e[k*128 +: 128]);
                            break;
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_slot_valid", 32'(slot_valid), 0);
        check("rst_all_done", 32'(all_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rd_poly_zero", 32'(|rd_poly), 0);
        rst = 1'b0;
        tick();

        // Write in IDLE is ignored silently
        beat(0);
        check("idle_wr_err", 32'(err), 0);
        check("idle_wr_sv", 32'(slot_valid), 0);

        // Encryption, in-order full-throughput stream
        do_start(1'b0);
        check("enc_busy", 32'(busy), 1);
        for (int a = 0; a < 96; a++) begin
            beat(a);
            if (a == 30) check("enc_sv_before32", 32'(slot_valid), 0);
            if (a == 31) check("enc_sv_32", 32'(slot_valid), 3'b001);
            if (a == 63) check("enc_sv_64", 32'(slot_valid), 3'b011);
            if (a == 94) check("enc_done_before96", 32'(all_done), 0);
        end
        check("enc_sv_96", 32'(slot_valid), 3'b111);
        check("enc_all_done", 32'(all_done), 1);
        check("enc_busy_done", 32'(busy), 0);
        check("enc_err", 32'(err), 0);
        do_read(1, 1'b1);
        check("enc_rd1_word0", rd_poly[31:0], 32'h20202020);
        do_read(0, 1'b1);
        do_read(2, 1'b1);
        check("enc_rd_err", 32'(err), 0);
        do_read(3, 1'b0);
        check("enc_rd3_err", 32'(err), 1);

        // Decryption: slot 0 only; later beat in DONE flags err
        do_start(1'b1);
        check("dec_err_cleared", 32'(err), 0);
        beats(0, 31);
        check("dec_all_done", 32'(all_done), 1);
        check("dec_err0", 32'(err), 0);
        beat(32);
        check("dec_extra_err", 32'(err), 1);
        check("dec_extra_sv", 32'(slot_valid), 3'b001);
        do_read(0, 1'b1);

        // Out-of-order word: dropped, counter holds at 2
        do_start(1'b0);
        beats(0, 1);
        beat(3);
        check("ooo_err", 32'(err), 1);
        beats(2, 31);
        check("ooo_sv", 32'(slot_valid), 3'b001);
        check("ooo_err_sticky", 32'(err), 1);
        do_read(0, 1'b1);

        // Read guard: slot 2 not yet complete
        do_start(1'b0);
        beats(0, 30);
        do_read(2, 1'b0);
        check("guard_slot2_err", 32'(err), 1);

        // Read guard: slot 3 does not exist
        do_start(1'b0);
        beats(0, 30);
        check("guard_pre_err", 32'(err), 0);
        do_read(3, 1'b0);
        check("guard_slot3_err", 32'(err), 1);

        // Read guard: final beat and read of same slot in one cycle
        do_start(1'b0);
        beats(0, 30);
        wr_valid = 1'b1; wr_addr = 7'd31; wr_data = pat(31);
        rd_req = 1'b1; rd_slot = 2'd0;
        tick();
        wr_valid = 1'b0; rd_req = 1'b0;
        check("same_cycle_err", 32'(err), 1);
        check("same_cycle_sv", 32'(slot_valid), 3'b001);
        check("same_cycle_no_rd", 32'(rd_valid), 0);
        do_read(0, 1'b1);

        // Restart mid-stream; start beats a same-cycle write and read
        do_start(1'b0);
        beats(0, 40);
        beat(100);
        check("restart_pre_err", 32'(err), 1);
        start = 1'b1; mux_enc_dec = 1'b1;
        wr_valid = 1'b1; wr_addr = 7'd0; wr_data = pat(0);
        rd_req = 1'b1; rd_slot = 2'd0;
        tick();
        start = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        check("restart_sv", 32'(slot_valid), 0);
        check("restart_err", 32'(err), 0);
        check("restart_busy", 32'(busy), 1);
        beats(0, 31);
        check("restart_all_done", 32'(all_done), 1);
        check("restart_err_end", 32'(err), 0);

        // Reset during a stream
        do_start(1'b0);
        beats(0, 40);
        beat(100);
        rst = 1'b1;
        wr_valid = 1'b1; wr_addr = 7'd41; wr_data = pat(41);
        tick();
        wr_valid = 1'b0;
        check("mid_rst_sv", 32'(slot_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_done", 32'(all_done), 0);
        check("mid_rst_rd_poly", 32'(|rd_poly), 0);
        rst = 1'b0;
        beat(0);
        check("post_rst_idle_err", 32'(err), 0);
        check("post_rst_idle_busy", 32'(busy), 0);
        do_read(0, 1'b0);
        check("idle_read_err", 32'(err), 1);
        do_start(1'b1);
        beats(0, 31);
        check("post_rst_all_done", 32'(all_done), 1);
        check("post_rst_err", 32'(err), 0);

        tick();
        tick();
        check("pending_reads", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
